input_conditioner: RTL

- Conditions raw input-pad levels before they reach the chip core logic.
- Per input: an N-flop synchronizer, then a counter-based debouncer, then an optional edge detector.
- Sits between the input pad cells and the core's input bus. clean_out drives the core's input_in directly.
- Removes metastability and short glitches, so core logic qualified on input levels sees only stable values.

---
 rtl/input_conditioner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-pad synchronizer, counter debouncer and optional
// edge detector between the pad ring and the core input bus.
// Optional feature macro: INPUT_CONDITIONER_EDGE_EN enables the registered
// rise/fall/changed outputs. When it is undefined they are tied to 0.

// One pad: synchronizer chain followed by the debounce counter.
module input_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic debounce_en,
  output logic clean
`ifdef INPUT_CONDITIONER_EDGE_EN
  , output logic clean_nxt
`endif
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Next state: plain shift for the synchronizer. The level is accepted
  // only after it has differed from clean for DEBOUNCE_CYCLES edges.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (!debounce_en) begin
      // Bypass mode: follow the synchronizer, and drop any partial count.
      clean_d = sync_bit;
      cnt_d   = '0;
    end else if (sync_bit == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = sync_bit;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset clears the chain so pad_in is ignored during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;
`ifdef INPUT_CONDITIONER_EDGE_EN
  assign clean_nxt = clean_d;
`endif
endmodule

module input_conditioner #(
  parameter int NUM_INPUTS      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] pad_in,
  input  logic                  debounce_en,
  output logic [NUM_INPUTS-1:0] clean_out,
  output logic [NUM_INPUTS-1:0] rise,
  output logic [NUM_INPUTS-1:0] fall,
  output logic                  changed
);
`ifdef INPUT_CONDITIONER_EDGE_EN
  logic [NUM_INPUTS-1:0] clean_nxt;
`endif

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    input_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad        (pad_in[g]),
      .debounce_en(debounce_en),
      .clean      (clean_out[g])
`ifdef INPUT_CONDITIONER_EDGE_EN
      , .clean_nxt(clean_nxt[g])
`endif
    );
  end

`ifdef INPUT_CONDITIONER_EDGE_EN
  logic [NUM_INPUTS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic                  changed_q, changed_d;

  // Edges are taken from the lane's next value so the pulses line up with
  // the first cycle clean_out shows the new level.
  always_comb begin
    rise_d    = clean_nxt & ~clean_out;
    fall_d    = ~clean_nxt & clean_out;
    changed_d = |(rise_d | fall_d);
  end

  // Edge pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif
endmodule
